// File: rtl/branch_ctrl.sv
// branch_ctrl: sequences the branch comparator for cond branches, JAL and JALR; emits redirect/flush, error pulses or link writeback.
// Optional BRANCH_PREDICT_EN: static BTFN prediction for cond branches (redirect only on mispredict).
module branch_ctrl #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [1:0]      issue_kind,
  input  logic [2:0]      issue_func,
  input  logic [XLEN-1:0] issue_pc,
  input  logic [XLEN-1:0] issue_rs1,
  input  logic [XLEN-1:0] issue_rs2,
  input  logic [XLEN-1:0] issue_imm,
  input  logic [RD_W-1:0] issue_rd,
  output logic [XLEN-1:0] cmp_a,
  output logic [XLEN-1:0] cmp_b,
  output logic [2:0]      cmp_func,
  input  logic            cmp_taken,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic [RD_W-1:0] res_rd,
  output logic            misalign_err,
  output logic            illegal_err
);
  typedef enum logic [1:0] {IDLE, EVAL, RESOLVE, WB} state_t;
  state_t          state_q;
  logic [1:0]      kind_q;
  logic [2:0]      func_q;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q, redirect_pc_q, res_data_q;
  logic [RD_W-1:0] rd_q, res_rd_q;
  logic            redirect_q, flush_q, res_valid_q, misalign_q, illegal_q;
  logic [XLEN-1:0] jalr_sum, target_d, link_d, redir_pc_d;
  logic            is_jump, illegal_d, taken_d, misalign_d, redir_d, pred_d;
  assign issue_ready    = state_q == IDLE;
  assign cmp_a          = rs1_q;
  assign cmp_b          = rs2_q;
  assign cmp_func       = func_q;
  assign redirect_valid = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign res_rd         = res_rd_q;
  assign misalign_err   = misalign_q;
  assign illegal_err    = illegal_q;
  always_comb begin
    is_jump    = kind_q == 2'd1 || kind_q == 2'd2;
    illegal_d  = kind_q == 2'd3 || (kind_q == 2'd0 && func_q[2:1] == 2'b01);
    jalr_sum   = rs1_q + imm_q;
    target_d   = kind_q == 2'd2 ? {jalr_sum[XLEN-1:1], 1'b0} : pc_q + imm_q;
    link_d     = pc_q + XLEN'(4);
    taken_d    = is_jump || (kind_q == 2'd0 && cmp_taken);
    misalign_d = taken_d && target_d[1:0] != 2'b00;
`ifdef BRANCH_PREDICT_EN
    // backward cond branches were already followed by fetch
    pred_d     = kind_q == 2'd0 && imm_q[XLEN-1];
    redir_d    = is_jump || (kind_q == 2'd0 && cmp_taken != pred_d);
    redir_pc_d = (pred_d && !cmp_taken) ? link_d : target_d;
`else
    pred_d     = 1'b0;
    redir_d    = taken_d;
    redir_pc_d = target_d;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      kind_q        <= '0;
      func_q        <= '0;
      pc_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      rd_q          <= '0;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_rd_q      <= '0;
      misalign_q    <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      case (state_q)
        IDLE: if (issue_valid) begin
          kind_q  <= issue_kind;
          func_q  <= issue_func;
          pc_q    <= issue_pc;
          rs1_q   <= issue_rs1;
          rs2_q   <= issue_rs2;
          imm_q   <= issue_imm;
          rd_q    <= issue_rd;
          state_q <= EVAL;
        end
        EVAL: begin
          illegal_q  <= illegal_d;
          misalign_q <= !illegal_d && misalign_d;
          redirect_q <= !illegal_d && !misalign_d && redir_d;
          flush_q    <= !illegal_d && !misalign_d && redir_d;
          if (!illegal_d && !misalign_d && redir_d) redirect_pc_q <= redir_pc_d;
          state_q    <= RESOLVE;
        end
        RESOLVE: if (is_jump && !misalign_q) begin
          res_valid_q <= 1'b1;
          res_data_q  <= link_d;
          res_rd_q    <= rd_q;
          state_q     <= WB;
        end else begin
          state_q <= IDLE;
        end
        WB: if (res_ready) begin
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: scoreboard bench for branch_ctrl; reference model computes expected pulses/writebacks from the ISA rules.
module tb_branch_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        issue_valid = 1'b0, issue_ready;
  logic [1:0]  issue_kind = '0;
  logic [2:0]  issue_func = '0;
  logic [31:0] issue_pc = '0, issue_rs1 = '0, issue_rs2 = '0, issue_imm = '0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] cmp_a, cmp_b, redirect_pc, res_data;
  logic [2:0]  cmp_func;
  logic        cmp_taken, redirect_valid, flush, res_valid, misalign_err, illegal_err;
  logic        res_ready = 1'b0;
  logic [4:0]  res_rd;
  int tests = 0, fails = 0;
  typedef struct {int typ; logic [31:0] pc;} ev_t;
  typedef struct {logic [31:0] data; logic [4:0] rd;} wb_t;
  ev_t evq[$];
  wb_t wbq[$];

  branch_ctrl #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_kind(issue_kind), .issue_func(issue_func), .issue_pc(issue_pc),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_imm(issue_imm), .issue_rd(issue_rd),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_func(cmp_func), .cmp_taken(cmp_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
    .misalign_err(misalign_err), .illegal_err(illegal_err));

  always #5 clk = ~clk;

  // environment comparator; reserved funct3 reports taken so the design must ignore it
  function automatic logic cmp_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b1;
    endcase
  endfunction
  assign cmp_taken = cmp_model(cmp_a, cmp_b, cmp_func);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (redirect_valid || misalign_err || illegal_err) begin
      ev_t e;
      chk("flush_eq_redirect", 32'(flush), 32'(redirect_valid));
      if (evq.size() == 0) chk("unexpected_pulse", {29'd0, illegal_err, misalign_err, redirect_valid}, 32'd0);
      else begin
        e = evq.pop_front();
        chk("pulse_type", redirect_valid ? 32'd1 : misalign_err ? 32'd2 : 32'd3, 32'(e.typ));
        chk("pulse_onehot", 32'(redirect_valid) + 32'(misalign_err) + 32'(illegal_err), 32'd1);
        if (e.typ == 1) chk("redirect_pc", redirect_pc, e.pc);
      end
    end
    if (res_valid) begin
      if (wbq.size() == 0) chk("unexpected_res_valid", 32'd1, 32'd0);
      else begin
        chk("res_data", res_data, wbq[0].data);
        chk("res_rd", 32'(res_rd), 32'(wbq[0].rd));
        if (res_ready) void'(wbq.pop_front());
      end
    end
  end

  // issue one instruction, push expected responses, then check the issue-to-ready latency
  task automatic issue(input logic [1:0] k, input logic [2:0] f, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [4:0] rd, input int stall);
    logic [31:0] tgt;
    logic tk, pred;
    int exp_lat, lat, wbcnt;
    tgt = (k == 2'd2) ? ((rs1 + imm) & 32'hFFFF_FFFE) : pc + imm;
    tk = cmp_model(rs1, rs2, f);
    exp_lat = 2;
    if (k == 2'd3 || (k == 2'd0 && (f == 3'd2 || f == 3'd3))) evq.push_back('{3, 32'd0});
    else if (k != 2'd0) begin
      if (tgt % 4 != 0) evq.push_back('{2, 32'd0});
      else begin
        evq.push_back('{1, tgt});
        wbq.push_back('{pc + 4, rd});
        exp_lat = 3 + stall;
      end
    end else begin
`ifdef BRANCH_PREDICT_EN
      pred = imm >= 32'h8000_0000;
`else
      pred = 1'b0;
`endif
      if (tk && tgt % 4 != 0) evq.push_back('{2, 32'd0});
      else if (tk && !pred) evq.push_back('{1, tgt});
      else if (!tk && pred) evq.push_back('{1, pc + 4});
    end
    chk("issue_ready_idle", 32'(issue_ready), 32'd1);
    issue_valid = 1'b1; issue_kind = k; issue_func = f; issue_pc = pc;
    issue_rs1 = rs1; issue_rs2 = rs2; issue_imm = imm; issue_rd = rd;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    issue_rs1 = $urandom; issue_rs2 = $urandom; issue_pc = $urandom; issue_imm = $urandom;
    lat = 0; wbcnt = 0;
    while (!issue_ready && lat < 30) begin
      if (res_valid) begin
        res_ready = wbcnt >= stall;
        wbcnt++;
      end
      @(posedge clk); #1;
      lat++;
    end
    res_ready = 1'b0;
    chk("issue_latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #1;
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_pulses", {28'd0, redirect_valid, flush, misalign_err, illegal_err}, 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_cmp_a", cmp_a, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    issue(2'd0, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 5'd0, 0);
    issue(2'd0, 3'd6, 32'h140, 32'hFFFF_FFFF, 32'd1, 32'h10, 5'd0, 0);
    issue(2'd0, 3'd4, 32'h140, 32'hFFFF_FFFF, 32'd1, 32'h10, 5'd0, 0);
    issue(2'd1, 3'd0, 32'h200, 32'd0, 32'd0, 32'h40, 5'd7, 3);
    issue(2'd2, 3'd0, 32'h400, 32'h1007, 32'd0, 32'd0, 5'd3, 0);
    issue(2'd0, 3'd2, 32'h500, 32'd1, 32'd1, 32'h8, 5'd0, 0);
    issue(2'd3, 3'd0, 32'h500, 32'd1, 32'd1, 32'h8, 5'd1, 0);
    issue(2'd2, 3'd0, 32'h600, 32'h1001, 32'd0, 32'h3, 5'd0, 1);
    issue(2'd1, 3'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h8, 5'd9, 0);
    issue(2'd0, 3'd1, 32'h300, 32'd3, 32'd3, 32'hFFFF_FFF8, 5'd0, 0);
    issue(2'd0, 3'd1, 32'h300, 32'd3, 32'd4, 32'hFFFF_FFF8, 5'd0, 0);
    // async reset in the middle of EVAL of a taken BNE: nothing may come out
    issue_valid = 1'b1; issue_kind = 2'd0; issue_func = 3'd1; issue_pc = 32'h700;
    issue_rs1 = 32'd1; issue_rs2 = 32'd2; issue_imm = 32'h10;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    chk("eval_not_ready", 32'(issue_ready), 32'd0);
    rst = 1'b1; #1;
    chk("midrst_issue_ready", 32'(issue_ready), 32'd1);
    chk("midrst_pulses", {28'd0, redirect_valid, flush, misalign_err, illegal_err}, 32'd0);
    chk("midrst_cmp_a", cmp_a, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    issue(2'd0, 3'd5, 32'h800, 32'd9, 32'd2, 32'h24, 5'd0, 0);
    for (int i = 0; i < 300; i++) begin
      logic [1:0] k;
      logic [2:0] f;
      logic [31:0] a, b, imm;
      k = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : a + 32'($urandom_range(0, 2)) - 32'd1);
      imm = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      if (k == 2'd2 && $urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
      issue(k, f, $urandom & 32'hFFFF_FFFC, a, b, imm, 5'($urandom), $urandom_range(0, 3));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("pulse_queue_drained", 32'(evq.size()), 32'd0);
    chk("wb_queue_drained", 32'(wbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
